rx_fifo: RTL and testbench

- Single-clock receive FIFO with width conversion: 8-bit byte writes in, 128-bit word reads out.
- Capacity 4096 bytes, which is 256 read words.
- Sits between a byte-serial receive path and a wide datapath consumer.
- Gives full/empty and almost-full/almost-empty status so both sides can throttle.

---
 rtl/rx_fifo_if.sv | 30 +++
 rtl/rx_fifo.sv | 81 ++++++++
 tb/tb_rx_fifo.sv | 107 ++++++++++
 3 files changed

// File: rtl/rx_fifo_if.sv
// rx_fifo_if: byte write side and word read side of rx_fifo.
// RX_FIFO_WATER_LEVEL_EN adds the fill-level outputs.
interface rx_fifo_if #(
  parameter int WR_DEPTH_WIDTH = 12,
  parameter int WR_DATA_WIDTH  = 8,
  parameter int RD_DEPTH_WIDTH = 8,
  parameter int RD_DATA_WIDTH  = 128
);
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     wr_en;
  logic                     wr_full;
  logic                     almost_full;
  logic [RD_DATA_WIDTH-1:0] rd_data;
  logic                     rd_en;
  logic                     rd_empty;
  logic                     almost_empty;
`ifdef RX_FIFO_WATER_LEVEL_EN
  logic [WR_DEPTH_WIDTH:0]  wr_water_level;
  logic [RD_DEPTH_WIDTH:0]  rd_water_level;
  modport master (output wr_data, wr_en, rd_en,
                  input wr_full, almost_full, rd_data, rd_empty, almost_empty, wr_water_level, rd_water_level);
  modport slave  (input wr_data, wr_en, rd_en,
                  output wr_full, almost_full, rd_data, rd_empty, almost_empty, wr_water_level, rd_water_level);
`else
  modport master (output wr_data, wr_en, rd_en,
                  input wr_full, almost_full, rd_data, rd_empty, almost_empty);
  modport slave  (input wr_data, wr_en, rd_en,
                  output wr_full, almost_full, rd_data, rd_empty, almost_empty);
`endif
endinterface

// File: rtl/rx_fifo.sv
// rx_fifo: single-clock FIFO packing 8-bit writes into 128-bit reads, little-endian.
// Define RX_FIFO_WATER_LEVEL_EN to expose registered write/read fill levels.
module rx_fifo #(
  parameter int WR_DEPTH_WIDTH   = 12,
  parameter int WR_DATA_WIDTH    = 8,
  parameter int RD_DEPTH_WIDTH   = 8,
  parameter int RD_DATA_WIDTH    = 128,
  parameter int ALMOST_FULL_NUM  = 255,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic      clk,
  input  logic      rst,
  rx_fifo_if.slave  bus
);
  localparam int RW = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
  localparam logic [WR_DEPTH_WIDTH:0] FULL_LVL = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
  localparam logic [WR_DEPTH_WIDTH:0] AF_LVL   = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [RD_DEPTH_WIDTH:0] AE_LVL   = (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  logic [RD_DATA_WIDTH-1:0] mem [2**RD_DEPTH_WIDTH];
  logic [WR_DEPTH_WIDTH:0]  wr_ptr_q, wr_ptr_d, wr_level_d;
  logic [RD_DEPTH_WIDTH:0]  rd_ptr_q, rd_ptr_d, rd_level_d;
  logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic wr_full_q, wr_full_d, almost_full_q, almost_full_d;
  logic rd_empty_q, rd_empty_d, almost_empty_q, almost_empty_d;
  logic wr_acc, rd_acc;
  // Flags are computed from the post-edge pointers so they never lag an operation.
  always_comb begin
    wr_acc         = bus.wr_en & ~wr_full_q;
    rd_acc         = bus.rd_en & ~rd_empty_q;
    wr_ptr_d       = wr_ptr_q + (WR_DEPTH_WIDTH+1)'(wr_acc);
    rd_ptr_d       = rd_ptr_q + (RD_DEPTH_WIDTH+1)'(rd_acc);
    wr_level_d     = wr_ptr_d - {rd_ptr_d, {RW{1'b0}}};
    rd_level_d     = wr_level_d[WR_DEPTH_WIDTH:RW];
    rd_data_d      = rd_acc ? mem[rd_ptr_q[RD_DEPTH_WIDTH-1:0]] : rd_data_q;
    wr_full_d      = wr_level_d == FULL_LVL;
    almost_full_d  = wr_level_d >= AF_LVL;
    rd_empty_d     = rd_level_d == '0;
    almost_empty_d = rd_level_d <= AE_LVL;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rd_data_q      <= '0;
      wr_full_q      <= 1'b0;
      almost_full_q  <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_data_q      <= rd_data_d;
      wr_full_q      <= wr_full_d;
      almost_full_q  <= almost_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_empty_q <= almost_empty_d;
    end
  // Storage is not reset; the pointer reset alone discards its contents.
  always_ff @(posedge clk)
    if (wr_acc)
      mem[wr_ptr_q[WR_DEPTH_WIDTH-1:RW]][int'(wr_ptr_q[RW-1:0])*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= bus.wr_data;
  assign bus.rd_data      = rd_data_q;
  assign bus.wr_full      = wr_full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.rd_empty     = rd_empty_q;
  assign bus.almost_empty = almost_empty_q;
`ifdef RX_FIFO_WATER_LEVEL_EN
  logic [WR_DEPTH_WIDTH:0] wr_water_level_q;
  logic [RD_DEPTH_WIDTH:0] rd_water_level_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_water_level_q <= '0;
      rd_water_level_q <= '0;
    end else begin
      wr_water_level_q <= wr_level_d;
      rd_water_level_q <= rd_level_d;
    end
  assign bus.wr_water_level = wr_water_level_q;
  assign bus.rd_water_level = rd_water_level_q;
`endif
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed stimulus with a byte-queue model; read words are checked by a
// separate monitor that pops expected words from a scoreboard queue.
module tb_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk = 1'b0;
  logic chk_q = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0]   bq[$];
  logic [127:0] exp_q[$];
  logic [127:0] last = '0;

  rx_fifo_if bus();
  rx_fifo dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(posedge clk) chk_q <= chk;

  always @(negedge clk)
    if (chk_q) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_data: got %h expected <no entry in scoreboard>", bus.rd_data);
      end else check("rd_data", bus.rd_data, exp_q.pop_front());
    end

  task automatic chk_flags();
    int n = bq.size();
    check("wr_full", 128'(bus.wr_full), 128'(n == 4096));
    check("almost_full", 128'(bus.almost_full), 128'(n >= 255));
    check("rd_empty", 128'(bus.rd_empty), 128'(n < 16));
    check("almost_empty", 128'(bus.almost_empty), 128'((n / 16) <= 4));
  endtask

  task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
    logic [127:0] w;
    logic wok;
    wok = we && bq.size() < 4096;
    bus.wr_en = we;
    bus.wr_data = wd;
    bus.rd_en = re;
    chk = re;
    if (re) begin
      if (bq.size() >= 16) begin
        for (int i = 0; i < 16; i++) w[i*8 +: 8] = bq.pop_front();
        last = w;
      end
      exp_q.push_back(last);
    end
    if (wok) bq.push_back(wd);
    @(negedge clk);
    chk = 1'b0;
    chk_flags();
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_flags();
    check("reset rd_data", bus.rd_data, 128'h0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("word0", bus.rd_data, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("ignored read", bus.rd_data, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hAA;
    #2 rst = 1'b0;
    #1;
    bq.delete();
    last = '0;
    chk_flags();
    check("async reset rd_data", bus.rd_data, 128'h0);
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4097; i++) cyc(1'b1, 8'hFF - i[7:0], 1'b0);
    check("full word0", 128'(bq[0]), 128'hFF);
    for (int i = 0; i < 257; i++) cyc(1'b0, 8'h00, 1'b1);
    check("last word", bus.rd_data, 128'h00010203_04050607_08090a0b_0c0d0e0f);
    for (int i = 0; i < 200; i++) cyc(1'b1, 8'(i * 5), 1'b0);
    for (int i = 0; i < 9000; i++) cyc(1'b1, 8'(i * 7 + 3), 1'b1);
    for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    check("scoreboard drained", 128'(exp_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
